instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the 8K x 32 synchronous-read instruction ROM (13-bit word addr, 1-cycle

---
 rtl/instr_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for an 8K x 32 synchronous-read instruction ROM: owns the PC, tracks the
// single in-flight read, buffers returned words and hands {pc, instr} to decode over valid/ready.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [12:0] o_imem_addr,
  input  logic [31:0] i_imem_rd,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_fetch_cnt
);

  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   fetch_cnt;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] occ;

  logic          pop;
  logic          push;
  logic          issue;
  logic [OW:0]   credit;
  logic [31:0]   pc_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_valid     = (occ != '0);
  assign o_pc        = pc_mem[rd_ptr];
  assign o_instr     = instr_mem[rd_ptr];
  assign o_fetch_cnt = fetch_cnt;

  assign pop     = o_valid & i_ready;
  assign push    = inflight;
  assign pc_next = fetch_pc + 32'd4;

  // Credit counts buffered words plus the one in flight, less the word leaving this cycle,
  // so a returning word can always be pushed.
  assign credit = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(pop);
  assign issue  = (state == RUN) & i_en & ~i_redirect & (credit < (OW+1)'(FIFO_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      o_imem_addr <= RESET_PC[14:2];
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_cnt   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      state <= i_en ? RUN : IDLE;
      if (pop) fetch_cnt <= fetch_cnt + 32'd1;

      if (i_redirect) begin
        // Wrong-path words, buffered or returning, are dropped.
        fetch_pc    <= {i_redirect_pc[31:2], 2'b00};
        o_imem_addr <= i_redirect_pc[14:2];
        inflight    <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        occ         <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= pc_next;
          o_imem_addr <= pc_next[14:2];
        end
        if (push) begin
          pc_mem[wr_ptr]    <= inflight_pc;
          instr_mem[wr_ptr] <= i_imem_rd;
          wr_ptr            <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        occ <= occ + OW'(push) - OW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed latency/stall/redirect/wrap cases, then random traffic
// checked against a stream-level model of the expected PC sequence and transfer count.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [12:0] addr1, addr2;
  logic [31:0] rd1, rd2;
  logic        valid1, valid2;
  logic [31:0] pc1, instr1, cnt1, pc2, instr2, cnt2;

  logic [31:0] rom [0:8191];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        held;
  logic [31:0] held_pc, held_instr;
  logic [12:0] addr_snap;
  int          seen;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_imem_addr(addr1), .i_imem_rd(rd1),
    .o_valid(valid1), .i_ready(ready), .o_pc(pc1), .o_instr(instr1), .o_fetch_cnt(cnt1)
  );

  instr_fetch_ctrl #(.RESET_PC(32'h0000_7FF8), .FIFO_DEPTH(2)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_imem_addr(addr2), .i_imem_rd(rd2),
    .o_valid(valid2), .i_ready(ready), .o_pc(pc2), .o_instr(instr2), .o_fetch_cnt(cnt2)
  );

  // Synchronous-read ROM, one cycle latency
  always @(posedge clk) begin
    rd1 <= rom[addr1];
    rd2 <= rom[addr2];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, then check the model against outputs before the edge.
  task automatic step(input logic e, input logic r, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    en = e; ready = r; redirect = rd; redirect_pc = rpc;
    #1;
    check_eq("fetch_cnt", cnt1, exp_cnt);
    if (held) begin
      check_eq("stall_valid", {31'd0, valid1}, 32'd1);
      check_eq("stall_pc", pc1, held_pc);
      check_eq("stall_instr", instr1, held_instr);
    end
    if (valid1 && r) begin
      check_eq("xfer_pc", pc1, exp_pc);
      check_eq("xfer_instr", instr1, rom[exp_pc[14:2]]);
      exp_pc  = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
    end
    held       = valid1 && !r && !rd;
    held_pc    = pc1;
    held_instr = instr1;
    if (rd) exp_pc = {rpc[31:2], 2'b00};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    check_eq("rst_valid", {31'd0, valid1}, 32'd0);
    check_eq("rst_cnt", cnt1, 32'd0);
    check_eq("rst_pc", pc1, 32'd0);
    check_eq("rst_instr", instr1, 32'd0);
    check_eq("rst_addr", {19'd0, addr1}, 32'd0);
    check_eq("rst_addr_wrap", {19'd0, addr2}, 32'h1FFE);
    exp_pc = 32'd0; exp_cnt = 32'd0; held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] wrap_pc [3];
    logic [31:0] wrap_in [3];
    wrap_pc = '{32'h7FF8, 32'h7FFC, 32'h8000};
    wrap_in = '{32'h1FFE, 32'h1FFF, 32'h0};
    exp_pc = '0; exp_cnt = '0; held = 1'b0;
    for (int i = 0; i < 8192; i++) rom[i] = i;

    // Start-up latency and streaming; wrap instance runs in lockstep
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check_eq("lat_valid", {31'd0, valid1}, (k >= 3) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 5) begin
        check_eq("wrap_pc", pc2, wrap_pc[k-3]);
        check_eq("wrap_instr", instr2, wrap_in[k-3]);
      end
    end

    // Stall for 5 cycles: outputs hold and issuing stops
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      if (s == 1) addr_snap = addr1;
      if (s >= 2) check_eq("stall_addr", {19'd0, addr1}, {19'd0, addr_snap});
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Fetch enable dropped for 3 cycles
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      if (k == 0) addr_snap = addr1;
      else check_eq("en_addr", {19'd0, addr1}, {19'd0, addr_snap});
      if (k == 2) check_eq("en_drained", {31'd0, valid1}, 32'd0);
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (j == 2) check_eq("en_resume_lo", {31'd0, valid1}, 32'd0);
      if (j == 3) check_eq("en_resume_hi", {31'd0, valid1}, 32'd1);
    end

    // Redirect to a misaligned target while streaming
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (j < 2) check_eq("redir_gap", {31'd0, valid1}, 32'd0);
      if (j == 2) begin
        check_eq("redir_valid", {31'd0, valid1}, 32'd1);
        check_eq("redir_pc", pc1, 32'h100);
        check_eq("redir_instr", instr1, 32'h40);
      end
    end

    // Redirect near the top of the 32-bit space: PC and ROM address both wrap
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (j == 4) check_eq("pcwrap_pc", pc1, 32'h0);
    end

    // Redirect while idle: PC moves, nothing issued
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("idle_redir_addr", {19'd0, addr1}, 32'h80);
    check_eq("idle_redir_valid", {31'd0, valid1}, 32'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Fill the buffer, then reset mid-stream
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("full_valid", {31'd0, valid1}, 32'd1);
    for (int i = 0; i < 8192; i++) rom[i] = $urandom;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0), $urandom);
    end

    // Liveness
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (valid1) seen++;
    end
    check_eq("live", {31'd0, (seen > 0)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
